// File: rtl/layer_argmax_if.sv
// Handshake bundle between the final fully connected layer, the argmax stage
// and the result consumer.
//   in_data/in_valid/in_ready    : score vector in, valid/ready
//   out_idx/out_max/out_valid/out_ready : winning class out, valid/ready
//   busy                         : stage is scanning or holding a result
// master = upstream/consumer side, slave = the argmax stage.
interface layer_argmax_if #(
    parameter int unsigned N     = 10,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
);
    logic [WIDTH-1:0] in_data [N-1:0];
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] out_max;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_idx, out_max, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_idx, out_max, out_valid, busy
    );
endinterface

// File: rtl/layer_argmax.sv
// Classifier stage: captures one score vector, optionally clamps negatives to
// zero, scans it one element per cycle and returns index and value of the
// first maximum.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any frame in flight
//   bus  : layer_argmax_if slave (vector in, result out, busy)
module layer_argmax #(
    parameter int unsigned N       = 10,
    parameter int unsigned WIDTH   = 16,
    parameter bit          RELU_EN = 1'b1,
    parameter int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    layer_argmax_if.slave bus
);
    localparam int unsigned LAST = N - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic signed [WIDTH-1:0] score_q [N];
    logic signed [WIDTH-1:0] best_val_q;
    logic [IDX_W-1:0]        best_idx_q;
    logic [IDX_W-1:0]        cnt_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;

    logic signed [WIDTH-1:0] relu_d [N];
    logic signed [WIDTH-1:0] cand_d;

    // ReLU at capture so the scan only ever sees final scores.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            relu_d[k] = bus.in_data[k];
            if (RELU_EN && bus.in_data[k][WIDTH-1]) begin
                relu_d[k] = '0;
            end
        end
    end

    assign cand_d = score_q[cnt_q];

    // Capture / scan / hold FSM; strict '>' keeps the lower index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            cnt_q       <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                score_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        for (int unsigned k = 0; k < N; k++) begin
                            score_q[k] <= relu_d[k];
                        end
                        best_val_q <= relu_d[0];
                        best_idx_q <= '0;
                        cnt_q      <= IDX_W'(1);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (N == 1) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (cand_d > best_val_q) begin
                        best_val_q <= cand_d;
                        best_idx_q <= cnt_q;
                    end
                    if (cnt_q == IDX_W'(LAST)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_idx   = best_idx_q;
    assign bus.out_max   = best_val_q;
endmodule

// File: tb/tb_layer_argmax.sv
// Bench for layer_argmax: two instances (ReLU on / ReLU off) driven in lockstep
// with identical stimulus; table vectors, hand sequences and random vectors
// checked against a reference model.
module tb_layer_argmax;
    localparam int unsigned N     = 10;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDX_W = 4;

    typedef logic [N-1:0][WIDTH-1:0] pvec_t;
    typedef int ivec_t [N];

    typedef struct {
        pvec_t            d;
        logic [IDX_W-1:0] ri;
        logic [WIDTH-1:0] rm;
        logic [IDX_W-1:0] ni;
        logic [WIDTH-1:0] nm;
        int               hold;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    layer_argmax_if #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W)) ifr ();
    layer_argmax_if #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W)) ifn ();

    layer_argmax #(.N(N), .WIDTH(WIDTH), .RELU_EN(1'b1), .IDX_W(IDX_W)) dut_r (
        .clk (clk),
        .rst (rst),
        .bus (ifr.slave)
    );

    layer_argmax #(.N(N), .WIDTH(WIDTH), .RELU_EN(1'b0), .IDX_W(IDX_W)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (ifn.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic pvec_t mk(input ivec_t a);
        pvec_t v;
        for (int k = 0; k < N; k++) v[k] = WIDTH'(a[k]);
        return v;
    endfunction

    // Reference: clamp if ReLU, take the maximum value, report its first index.
    function automatic void model(input pvec_t v, input bit relu,
                                  output logic [IDX_W-1:0] idx, output logic [WIDTH-1:0] mx);
        int s [N];
        int m;
        for (int k = 0; k < N; k++) s[k] = (relu && v[k][WIDTH-1]) ? 0 : int'($signed(v[k]));
        m = s[0];
        for (int k = 1; k < N; k++) if (s[k] > m) m = s[k];
        idx = '0;
        for (int k = N - 1; k >= 0; k--) if (s[k] == m) idx = IDX_W'(k);
        mx = WIDTH'(m);
    endfunction

    function automatic logic [WIDTH-1:0] rnd_score();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return WIDTH'(-int'($urandom_range(1, 20)));
            4:       return WIDTH'($urandom_range(0, 20));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    function automatic pvec_t rnd_vec();
        pvec_t v;
        for (int k = 0; k < N; k++) v[k] = rnd_score();
        if ($urandom_range(0, 1) == 1) v[$urandom_range(0, N - 1)] = v[$urandom_range(0, N - 1)];
        return v;
    endfunction

    task automatic set_inputs(input pvec_t v);
        for (int k = 0; k < N; k++) begin
            ifr.in_data[k] = v[k];
            ifn.in_data[k] = v[k];
        end
    endtask

    task automatic set_valid(input logic b);
        ifr.in_valid = b;
        ifn.in_valid = b;
    endtask

    task automatic set_oready(input logic b);
        ifr.out_ready = b;
        ifn.out_ready = b;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready_r"}, 32'(ifr.in_ready), 1);
        check({tag, " in_ready_n"}, 32'(ifn.in_ready), 1);
        check({tag, " out_valid_r"}, 32'(ifr.out_valid), 0);
        check({tag, " out_valid_n"}, 32'(ifn.out_valid), 0);
        check({tag, " busy_r"}, 32'(ifr.busy), 0);
        check({tag, " busy_n"}, 32'(ifn.busy), 0);
    endtask

    // Waits for in_ready, lets the accept edge pass, then scrambles in_data.
    task automatic accept(input string tag);
        int w = 0;
        while (!ifr.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, " accept in_ready"}, 32'(ifr.in_ready), 1);
        @(posedge clk);
        #1;
        check({tag, " busy_r"}, 32'(ifr.busy), 1);
        check({tag, " busy_n"}, 32'(ifn.busy), 1);
        check({tag, " in_ready drop"}, 32'(ifr.in_ready), 0);
        @(negedge clk);
        set_valid(1'b0);
        set_inputs(rnd_vec());
    endtask

    task automatic check_result(input string tag,
                                input logic [IDX_W-1:0] ri, input logic [WIDTH-1:0] rm,
                                input logic [IDX_W-1:0] ni, input logic [WIDTH-1:0] nm);
        check({tag, " valid_r"}, 32'(ifr.out_valid), 1);
        check({tag, " valid_n"}, 32'(ifn.out_valid), 1);
        check({tag, " idx_r"}, 32'(ifr.out_idx), 32'(ri));
        check({tag, " max_r"}, 32'(ifr.out_max), 32'(rm));
        check({tag, " idx_n"}, 32'(ifn.out_idx), 32'(ni));
        check({tag, " max_n"}, 32'(ifn.out_max), 32'(nm));
    endtask

    // Called right after accept(); expects out_valid after exactly N-1 edges.
    task automatic wait_result(input string tag,
                               input logic [IDX_W-1:0] ri, input logic [WIDTH-1:0] rm,
                               input logic [IDX_W-1:0] ni, input logic [WIDTH-1:0] nm);
        int e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
        end while (!ifr.out_valid && e < 40);
        check({tag, " latency"}, 32'(e), 32'(N - 1));
        check_result(tag, ri, rm, ni, nm);
    endtask

    // Expects out_ready high; the next edge completes the handshake.
    task automatic finish_hs(input string tag);
        @(posedge clk);
        #1;
        check_idle({tag, " post"});
    endtask

    task automatic run_vec(input string tag, input pvec_t v, input int hold,
                           input logic [IDX_W-1:0] ri, input logic [WIDTH-1:0] rm,
                           input logic [IDX_W-1:0] ni, input logic [WIDTH-1:0] nm);
        @(negedge clk);
        set_inputs(v);
        set_valid(1'b1);
        set_oready(hold == 0);
        accept(tag);
        wait_result(tag, ri, rm, ni, nm);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_result({tag, " hold"}, ri, rm, ni, nm);
            check({tag, " hold in_ready"}, 32'(ifr.in_ready), 0);
        end
        if (hold > 0) begin
            @(negedge clk);
            set_oready(1'b1);
        end
        finish_hs(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_rec_t tbl [6];
        ivec_t iv;
        pvec_t v1, v2;
        logic [IDX_W-1:0] ri, ni;
        logic [WIDTH-1:0] rm, nm;
        int seen;

        iv = '{3, -5, 12, 7, 12, 0, -1, 4, 9, 2};
        tbl[0] = '{d: mk(iv), ri: 4'd2, rm: 16'd12, ni: 4'd2, nm: 16'd12, hold: 0};
        iv = '{-100, -7, -300, -50, -50, -50, -50, -50, -50, -7};
        tbl[1] = '{d: mk(iv), ri: 4'd0, rm: 16'd0, ni: 4'd1, nm: 16'hFFF9, hold: 0};
        iv = '{0, 0, 0, 0, -32768, 0, 0, 0, 32767, 0};
        tbl[2] = '{d: mk(iv), ri: 4'd8, rm: 16'h7FFF, ni: 4'd8, nm: 16'h7FFF, hold: 2};
        iv = '{-32768, -32768, -32768, -32768, -32768, -32767, -32768, -32768, -32768, -32768};
        tbl[3] = '{d: mk(iv), ri: 4'd0, rm: 16'd0, ni: 4'd5, nm: 16'h8001, hold: 0};
        iv = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        tbl[4] = '{d: mk(iv), ri: 4'd0, rm: 16'd5, ni: 4'd0, nm: 16'd5, hold: 1};
        iv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        tbl[5] = '{d: mk(iv), ri: 4'd9, rm: 16'd10, ni: 4'd9, nm: 16'd10, hold: 0};

        rst = 1'b1;
        set_valid(1'b0);
        set_oready(1'b1);
        set_inputs('0);
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset idx_r", 32'(ifr.out_idx), 0);
        check("reset max_r", 32'(ifr.out_max), 0);
        check("reset idx_n", 32'(ifn.out_idx), 0);
        check("reset max_n", 32'(ifn.out_max), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_vec($sformatf("tbl%0d", t), tbl[t].d, tbl[t].hold,
                    tbl[t].ri, tbl[t].rm, tbl[t].ni, tbl[t].nm);
        end

        // Backpressure: result holds, a second vector waits, then is taken.
        iv = '{3, -5, 12, 7, 12, 0, -1, 4, 9, 2};
        v1 = mk(iv);
        v2 = rnd_vec();
        @(negedge clk);
        set_inputs(v1);
        set_valid(1'b1);
        set_oready(1'b0);
        accept("bp1");
        wait_result("bp1", 4'd2, 16'd12, 4'd2, 16'd12);
        @(negedge clk);
        set_inputs(v2);
        set_valid(1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check_result("bp1 hold", 4'd2, 16'd12, 4'd2, 16'd12);
            check("bp1 hold in_ready", 32'(ifr.in_ready), 0);
            check("bp1 hold busy", 32'(ifr.busy), 1);
        end
        @(negedge clk);
        set_oready(1'b1);
        @(posedge clk);
        #1;
        check_idle("bp1 release");
        model(v2, 1'b1, ri, rm);
        model(v2, 1'b0, ni, nm);
        accept("bp2");
        wait_result("bp2", ri, rm, ni, nm);
        finish_hs("bp2");

        // Reset four cycles after accept aborts the frame.
        @(negedge clk);
        set_inputs(tbl[0].d);
        set_valid(1'b1);
        accept("abort");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("abort reset");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (ifr.out_valid || ifn.out_valid) seen = 1;
        end
        check("abort no out_valid", 32'(seen), 0);
        run_vec("after_abort", tbl[0].d, 0, tbl[0].ri, tbl[0].rm, tbl[0].ni, tbl[0].nm);

        for (int r = 0; r < 40; r++) begin
            v1 = rnd_vec();
            model(v1, 1'b1, ri, rm);
            model(v1, 1'b0, ni, nm);
            run_vec($sformatf("rnd%0d", r), v1, int'($urandom_range(0, 3)), ri, rm, ni, nm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_argmax.md
Name: layer_argmax

Overview:
- Downstream classifier stage that consumes one completed output vector from a fully connected layer (OUTPUT_SIZE signed fixed-point scores).
- Captures the vector on a valid/ready handshake, optionally applies ReLU, then scans it sequentially, one element per cycle.
- Returns the winning class index and its score on an output valid/ready handshake.
- Sits between the final layer and the result/readout logic.

Parameters:
- N, 10, number of scores per vector; must equal the upstream OUTPUT_SIZE; legal range 1..256.
- WIDTH, 16, bits per score, two's complement signed.
- RELU_EN, 1, when 1 each score is clamped to 0 if negative before comparison.
- IDX_W, $clog2(N) with a minimum of 1, width of the class index.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH x N (unpacked array [WIDTH-1:0] in_data [N-1:0])  score vector from the layer.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector.
- out_idx  output  IDX_W  index of the maximum score.
- out_max  output  WIDTH  maximum score, after ReLU if RELU_EN=1.
- out_valid  output  1  out_idx and out_max are valid.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- Reset: synchronous, active-high. When rst=1 at a rising edge:
  - state goes to IDLE;
  - in_ready=1, out_valid=0, busy=0, out_idx=0, out_max=0;
  - the capture buffer and scan counter are cleared.
  - Reset asserted mid-SCAN or mid-DONE aborts the frame; no result is produced.
- States: IDLE, SCAN, DONE. in_ready is 1 only in IDLE. out_valid is 1 only in DONE.
- IDLE:
  - When in_valid && in_ready at edge T: register all N scores into the local buffer (ReLU applied at capture when RELU_EN=1).
  - Same edge: best_val <= score[0], best_idx <= 0, i <= 1.
  - Next state is SCAN, or DONE directly if N=1.
- SCAN:
  - Each cycle compare buf[i] against best_val using a signed comparison.
  - If buf[i] > best_val (strictly greater), update best_val and best_idx to buf[i] and i.
  - Ties keep the lower index.
  - When i == N-1, the compare is performed and state goes to DONE; otherwise i <= i+1.
- Latency: accept at edge T, out_valid=1 in the cycle following edge T+N-1 (N=10: the 9th edge after acceptance). Throughput is one vector per N+1 cycles minimum.
- DONE:
  - out_idx and out_max hold stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: state goes to IDLE and out_valid drops at that edge. in_ready rises the same edge, so a new vector is accepted no earlier than the following edge.
- in_data changes after the accept edge have no effect; the buffer is the only source during SCAN.
- in_valid while busy is ignored and not queued; upstream must hold it until in_ready.
- Arithmetic:
  - No widening is needed; compares are WIDTH-bit signed.
  - Most negative value (0x8000 at WIDTH=16) is handled correctly.
  - ReLU maps any value with MSB=1 to 0.
- All-equal vector: out_idx=0.

Test Plan:
- Reset then idle: rst for 2 cycles → in_ready=1, out_valid=0, out_idx=0, out_max=0, busy=0.
- RELU_EN=1, N=10, in_data={3,-5,12,7,12,0,-1,4,9,2} (index 0 first), out_ready=1 → out_idx=2, out_max=12, out_valid exactly 9 edges after the accept edge, one-cycle pulse.
- RELU_EN=0, all scores negative {-100,-7,-300,...,-7 at index 9, rest -50} → out_idx=1, out_max=-7. Ties resolve to the lower index.
- RELU_EN=1, all scores negative → out_idx=0, out_max=0. With 0x8000 at index 4 and 0x7FFF at index 8 (RELU_EN=0) → out_idx=8, out_max=0x7FFF.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs hold stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready → handshake completes, second vector accepted on the next edge and its result is correct.
- Reset mid-scan: assert rst 4 cycles after accept → out_valid never rises for that frame, in_ready=1 the cycle after reset. A following vector produces the correct result.
